// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download sequencer: region decode, FSM states and
// the buffered byte format carried through the write FIFO.
package rom_dl_pkg;

  localparam logic [24:0] GFX1_BASE_DEF = 25'h0E000;
  localparam logic [24:0] SP_BASE_DEF   = 25'h12000;
  localparam int          ENTRY_W       = 33;

  typedef enum logic [1:0] {REG_P1, REG_BRAM, REG_P2} region_e;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_e;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  function automatic region_e decode_region(input logic [24:0] addr,
                                            input logic [24:0] gfx1_base,
                                            input logic [24:0] sp_base);
    if (addr < gfx1_base)   return REG_P1;
    else if (addr < sp_base) return REG_BRAM;
    else                     return REG_P2;
  endfunction

endpackage

// File: rtl/dl_wr_fifo.sv
// First-word-fall-through write buffer; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module dl_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  // Extra pointer MSB tells full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes download bytes to SDRAM port1/port2 or the gfx1 BRAM with one toggle
// transaction in flight, then sequences rom_loaded and the core reset hold.
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] GFX1_BASE  = GFX1_BASE_DEF,
  parameter logic [24:0] SP_BASE    = SP_BASE_DEF,
  parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        res_n_i,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        soft_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        dl_wr,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        rom_busy,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);

  state_e       state_q, state_d;
  logic         wr_q, downl_q;
  logic         p1_req_q, p1_req_d, p2_req_q, p2_req_d;
  logic [22:0]  p1_a_q, p1_a_d, p2_a_q, p2_a_d;
  logic [1:0]   p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
  logic [15:0]  p1_d_q, p1_d_d, p2_d_q, p2_d_d;
  logic         dl_wr_q, dl_wr_d;
  logic [16:0]  dl_addr_q, dl_addr_d;
  logic [7:0]   dl_data_q, dl_data_d;
  logic         busy_q, busy_d, loaded_q, loaded_d;
  logic         core_rst_q, core_rst_d, ovf_q, ovf_d;
  logic [15:0]  cnt_q, cnt_d;

  logic               push, pop, outstanding, dl_rise, dl_fall;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  fifo_entry_t        ent;
  region_e            region;
  logic [23:0]        s;

  dl_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk_sys),
    .rst_n (res_n_i),
    .push  (push),
    .pop   (pop),
    .din   ({ioctl_addr, ioctl_dout}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ent         = fifo_entry_t'(fifo_dout);
  assign region      = decode_region(ent.addr, GFX1_BASE, SP_BASE);
  assign s           = ent.addr[23:0] - SP_BASE[23:0];
  assign push        = ioctl_wr & ~wr_q & ioctl_downl;
  assign dl_rise     = ioctl_downl & ~downl_q;
  assign dl_fall     = ~ioctl_downl & downl_q;
  // A single transaction across both ports; BRAM entries never block.
  assign outstanding = (p1_req_q ^ port1_ack) | (p2_req_q ^ port2_ack);
  assign pop         = ((state_q == LOAD) || (state_q == DRAIN)) &
                       ~fifo_empty & ~outstanding;

  always_comb begin
    p1_req_d = p1_req_q;  p1_a_d = p1_a_q;  p1_ds_d = p1_ds_q;  p1_d_d = p1_d_q;
    p2_req_d = p2_req_q;  p2_a_d = p2_a_q;  p2_ds_d = p2_ds_q;  p2_d_d = p2_d_q;
    dl_wr_d   = 1'b0;
    dl_addr_d = dl_addr_q;
    dl_data_d = dl_data_q;
    ovf_d     = ovf_q | (push & fifo_full & ~pop);
    if (pop) begin
      unique case (region)
        REG_P1: begin
          p1_a_d   = ent.addr[23:1];
          p1_ds_d  = {ent.addr[0], ~ent.addr[0]};
          p1_d_d   = {ent.data, ent.data};
          p1_req_d = ~p1_req_q;
        end
        REG_P2: begin
          // Sprite words are swizzled to match the sdram controller's layout.
          p2_a_d   = {s[23:16], s[13:0], s[15]};
          p2_ds_d  = {s[14], ~s[14]};
          p2_d_d   = {ent.data, ent.data};
          p2_req_d = ~p2_req_q;
        end
        default: begin
          dl_wr_d   = 1'b1;
          dl_addr_d = ent.addr[16:0];
          dl_data_d = ent.data;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    loaded_d   = loaded_q;
    core_rst_d = core_rst_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        core_rst_d = 1'b1;
        if (push) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: if (dl_fall) state_d = DRAIN;
      DRAIN: begin
        if (dl_rise) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end else if (fifo_empty && !outstanding) begin
          state_d  = HOLD;
          busy_d   = 1'b0;
          loaded_d = 1'b1;
          cnt_d    = RESET_HOLD;
        end
      end
      HOLD: begin
        if (dl_rise) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end else if (soft_reset) begin
          cnt_d = RESET_HOLD;
        end else if (cnt_q == 16'd0) begin
          state_d    = RUN;
          core_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RUN: begin
        if (dl_rise) begin
          state_d    = LOAD;
          busy_d     = 1'b1;
          core_rst_d = 1'b1;
        end else if (soft_reset) begin
          state_d    = HOLD;
          cnt_d      = RESET_HOLD;
          core_rst_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        core_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      downl_q    <= 1'b0;
      p1_req_q   <= 1'b0;  p1_a_q <= '0;  p1_ds_q <= '0;  p1_d_q <= '0;
      p2_req_q   <= 1'b0;  p2_a_q <= '0;  p2_ds_q <= '0;  p2_d_q <= '0;
      dl_wr_q    <= 1'b0;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      core_rst_q <= 1'b1;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= ioctl_wr;
      downl_q    <= ioctl_downl;
      p1_req_q   <= p1_req_d;  p1_a_q <= p1_a_d;  p1_ds_q <= p1_ds_d;  p1_d_q <= p1_d_d;
      p2_req_q   <= p2_req_d;  p2_a_q <= p2_a_d;  p2_ds_q <= p2_ds_d;  p2_d_q <= p2_d_d;
      dl_wr_q    <= dl_wr_d;
      dl_addr_q  <= dl_addr_d;
      dl_data_q  <= dl_data_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      core_rst_q <= core_rst_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign port1_req  = p1_req_q;
  assign port1_a    = p1_a_q;
  assign port1_ds   = p1_ds_q;
  assign port1_d    = p1_d_q;
  assign port2_req  = p2_req_q;
  assign port2_a    = p2_a_q;
  assign port2_ds   = p2_ds_q;
  assign port2_d    = p2_d_q;
  assign dl_wr      = dl_wr_q;
  assign dl_addr    = dl_addr_q;
  assign dl_data    = dl_data_q;
  assign rom_busy   = busy_q;
  assign rom_loaded = loaded_q;
  assign core_reset = core_rst_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboard bench: expected SDRAM/BRAM writes are queued as bytes are strobed
// and compared when a req toggles or dl_wr pulses; a latency model acks.
module tb_rom_dl_sequencer;

  localparam logic [24:0] GFX1 = 25'h0E000;
  localparam logic [24:0] SPB  = 25'h12000;

  logic        clk_sys = 1'b0, res_n_i = 1'b0;
  logic        ioctl_downl = 1'b0, ioctl_wr = 1'b0, soft_reset = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        port1_ack = 1'b0, port2_ack = 1'b0;
  logic        port1_req, port2_req, dl_wr;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [16:0] dl_addr;
  logic [7:0]  dl_data;
  logic        rom_busy, rom_loaded, core_reset, overflow;

  int          n_vec = 0, n_err = 0;
  logic [63:0] sb_q[$];
  int          lat = 2, lat_cnt = 0, done_cnt = 0;
  logic        p1_prev = 1'b0, p2_prev = 1'b0;

  rom_dl_sequencer #(.FIFO_DEPTH(4), .GFX1_BASE(GFX1), .SP_BASE(SPB),
                     .RESET_HOLD(16'd16)) dut (
    .clk_sys(clk_sys), .res_n_i(res_n_i), .ioctl_downl(ioctl_downl),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .soft_reset(soft_reset),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .rom_busy(rom_busy), .rom_loaded(rom_loaded), .core_reset(core_reset),
    .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Packed record: {pad, kind(1=p1,2=p2,3=bram), address, byte select, data}.
  function automatic logic [63:0] model(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] s;
    if (a < GFX1) return {21'd0, 2'd1, a[23:1], a[0], ~a[0], d, d};
    if (a < SPB)  return {21'd0, 2'd3, 6'd0, a[16:0], 2'd0, 8'd0, d};
    s = a - SPB;
    return {21'd0, 2'd2, s[23:16], s[13:0], s[15], s[14], ~s[14], d, d};
  endfunction

  task automatic take(input string tag, input logic [63:0] obs);
    if (sb_q.size() == 0) chk({tag, "_unexpected"}, obs, 64'd0);
    else                  chk(tag, obs, sb_q.pop_front());
  endtask

  always @(negedge clk_sys) begin
    if (res_n_i) begin
      if (port1_req !== p1_prev) take("p1_txn", {21'd0, 2'd1, port1_a, port1_ds, port1_d});
      if (port2_req !== p2_prev) take("p2_txn", {21'd0, 2'd2, port2_a, port2_ds, port2_d});
      if (dl_wr === 1'b1)        take("bram_wr", {21'd0, 2'd3, 6'd0, dl_addr, 2'd0, 8'd0, dl_data});
      p1_prev = port1_req;
      p2_prev = port2_req;
    end else begin
      p1_prev = 1'b0;
      p2_prev = 1'b0;
    end
  end

  // SDRAM side: acknowledge whichever toggle is pending after `lat` cycles.
  always @(posedge clk_sys) begin
    #1;
    if (!res_n_i) begin
      port1_ack = 1'b0;
      port2_ack = 1'b0;
      lat_cnt   = 0;
    end else if (port1_req !== port1_ack || port2_req !== port2_ack) begin
      if (lat_cnt >= lat) begin
        port1_ack = port1_req;
        port2_ack = port2_req;
        lat_cnt   = 0;
        done_cnt++;
      end else lat_cnt++;
    end
  end

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit expect_it);
    @(posedge clk_sys); #1;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (expect_it) sb_q.push_back(model(a, d));
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(sb_q.size() == 0 && port1_req === port1_ack && port2_req === port2_ack)
           && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    @(negedge clk_sys);
    chk({tag, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (rom_busy === 1'b1 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= 2000), 64'd0);
  endtask

  task automatic measure_hold(input string tag);
    int n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk(tag, 64'(n >= 16 && n <= 18), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [24:0] ra;
    repeat (3) @(negedge clk_sys);
    chk("rst_reqs", {port1_req, port2_req}, 2'b00);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_flags", {rom_busy, rom_loaded, overflow}, 3'b000);
    chk("rst_dl_wr", dl_wr, 1'b0);
    chk("rst_ports", {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d}, '0);

    @(posedge clk_sys); #1;
    res_n_i = 1'b1;
    lat = 2;
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b1;
    send(25'h00003, 8'hA5, 1'b1);
    send(25'h16001, 8'h3C, 1'b1);
    send(25'h0E010, 8'h77, 1'b1);
    send(25'h11FFF, 8'h11, 1'b1);
    send(25'h12000, 8'h22, 1'b1);
    send(25'h0DFFF, 8'h33, 1'b1);
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       ra = 25'($urandom_range(0, 32'h0DFFF));
        1:       ra = GFX1 + 25'($urandom_range(0, 32'h3FFF));
        default: ra = SPB + 25'($urandom_range(0, 32'h3FFFF));
      endcase
      send(ra, 8'($urandom), 1'b1);
    end
    wait_idle("dl1", 500);
    chk("busy_in_load", rom_busy, 1'b1);
    chk("core_reset_in_load", core_reset, 1'b1);

    @(posedge clk_sys); #1;
    ioctl_downl = 1'b0;
    wait_drain("drain1");
    chk("loaded_at_drain", {rom_loaded, rom_busy, core_reset}, 3'b101);
    chk("no_overflow", overflow, 1'b0);
    measure_hold("hold_after_drain");
    chk("run_core_reset", core_reset, 1'b0);

    repeat (3) @(posedge clk_sys);
    #1 soft_reset = 1'b1;
    @(posedge clk_sys); #1;
    soft_reset = 1'b0;
    chk("soft_reset_asserts", core_reset, 1'b1);
    measure_hold("hold_after_soft_reset");
    chk("soft_reset_keeps_loaded", rom_loaded, 1'b1);

    // Stalled SDRAM: one in flight plus four buffered; the sixth byte drops.
    lat = 40;
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("dl_rise_core_reset", {core_reset, rom_busy}, 2'b11);
    base = done_cnt;
    for (int i = 0; i < 6; i++) send(25'h00100 + 25'(2 * i), 8'(8'h40 + i), i < 5);
    @(negedge clk_sys);
    chk("overflow_set", overflow, 1'b1);
    wait_idle("stall", 600);
    chk("stall_done_count", 64'(done_cnt - base), 64'd5);
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b0;
    wait_drain("drain2");
    chk("overflow_sticky", {overflow, rom_loaded}, 2'b11);

    // Reset with a port1 transaction in flight.
    lat = 50;
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b1;
    send(25'h00020, 8'h99, 1'b1);
    repeat (5) @(negedge clk_sys);
    chk("txn_outstanding", 64'(port1_req !== port1_ack), 64'd1);
    @(posedge clk_sys); #1;
    res_n_i = 1'b0;
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    chk("midtxn_rst_reqs", {port1_req, port2_req}, 2'b00);
    chk("midtxn_rst_flags", {core_reset, rom_busy, rom_loaded, overflow}, 4'b1000);
    sb_q.delete();
    @(posedge clk_sys); #1;
    res_n_i = 1'b1;
    lat = 2;
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b1;
    send(25'h00010, 8'h5A, 1'b1);
    wait_idle("after_reset", 200);
    chk("idle_to_load_busy", {rom_busy, core_reset}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
